// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 size codes, FSM states and
// the latency-counter width.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Wide enough for the legal latency range 1..15.
  localparam int unsigned LAT_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } resp_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for data-memory accesses: byte enables and replicated store data,
// extended load data, and misalignment / illegal-code detection.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misalign,
  output logic        illegal
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sext;

  assign lane_b = rword[{addr_lo, 3'b000} +: 8];
  assign lane_h = rword[{addr_lo[1], 4'b0000} +: 16];
  assign sext   = ~funct3[2];

  always_comb begin
    be        = 4'b0000;
    wdata_sh  = '0;
    rdata_ext = '0;
    misalign  = 1'b0;
    illegal   = 1'b0;

    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = {{24{lane_b[7] & sext}}, lane_b};
      end
      F3_H, F3_HU: begin
        misalign  = addr_lo[0];
        be        = 4'b0011 << addr_lo;
        wdata_sh  = {2{wdata[15:0]}};
        rdata_ext = {{16{lane_h[15] & sext}}, lane_h};
      end
      F3_W: begin
        misalign  = (addr_lo != 2'b00);
        be        = 4'b1111;
        wdata_sh  = wdata;
        rdata_ext = rword;
      end
      default: illegal = 1'b1;
    endcase

    // Unsigned variants only exist for loads.
    if (write && funct3[2]) begin
      illegal = 1'b1;
    end

    if (misalign || illegal) begin
      be        = 4'b0000;
      rdata_ext = '0;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Stallable data-memory responder: valid/ready request, fixed access latency, registered
// response held until consumed. Store write and load read both commit on entry to StResp.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY - 1);

  resp_state_e      state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic [2:0]       f3_q, f3_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             accept;
  logic             commit;
  logic             cur_write;
  logic [2:0]       cur_f3;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_wdata;
  logic             in_range;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rword;
  logic [3:0]       be;
  logic [31:0]      wdata_sh;
  logic [31:0]      rdata_ext;
  logic             misalign;
  logic             illegal;
  logic             access_err;

  logic [31:0] mem [DEPTH_WORDS];

  assign accept = (state_q == StIdle) && req_valid;
  assign commit = (accept && (LATENCY == 1)) || ((state_q == StWait) && (cnt_q == LAT_W'(1)));

  // With LATENCY==1 the commit edge is the accept edge, so use the live request fields.
  assign cur_write = (state_q == StIdle) ? req_write  : wr_q;
  assign cur_f3    = (state_q == StIdle) ? req_funct3 : f3_q;
  assign cur_addr  = (state_q == StIdle) ? req_addr   : addr_q;
  assign cur_wdata = (state_q == StIdle) ? req_wdata  : wdata_q;

  assign in_range   = ({2'b00, cur_addr[31:2]} < DEPTH_WORDS);
  assign word_idx   = cur_addr[IDX_W+1:2];
  assign rword      = in_range ? mem[word_idx] : '0;
  assign access_err = misalign || illegal || !in_range;

  mem_lane_align u_lane_align (
    .write     (cur_write),
    .funct3    (cur_f3),
    .addr_lo   (cur_addr[1:0]),
    .wdata     (cur_wdata),
    .rword     (rword),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext),
    .misalign  (misalign),
    .illegal   (illegal)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          wr_d    = req_write;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = LAT_INIT;
          state_d = (LATENCY == 1) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - LAT_W'(1);
        if (cnt_q == LAT_W'(1)) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (commit) begin
      err_d   = access_err;
      rdata_d = (access_err || cur_write) ? '0 : rdata_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is intentionally not reset; only committed, error-free stores write it.
  always_ff @(posedge clk) begin
    if (rst_n && commit && cur_write && !access_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
